decode_stage: RTL

Second pipeline stage of the five-stage RV32I core, the consumer of the IF/ID register that fetch drives. It receives the fetched instruction and its PC, decodes control signals, reads the register file, and extends immediates. It captures everything into the ID/EX pipeline register. It also accepts the writeback port, detects load-use hazards, and squashes its output on a branch redirect.

---
 rtl/decode_stage_pkg.sv | 33 +++
 rtl/decode_stage_reg_file.sv | 26 ++
 rtl/decode_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcode, result-source and ALU encodings, immediate types and extension helper.
package decode_stage_pkg;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       alu_src;
    logic [2:0] alu_control;
    logic       branch;
    logic       jump;
  } ctrl_t;
  function automatic logic [31:0] imm_ext(input logic [31:0] i, input imm_t t);
    return t == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           t == IMM_B ? {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
           t == IMM_J ? {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0} :
                        {{20{i[31]}}, i[31:20]};
  endfunction
endpackage

// File: rtl/decode_stage_reg_file.sv
// reg_file: 32x32 register file, two async reads, one sync write, x0 hardwired to 0.
// DECODE_WB_BYPASS_EN makes a same-cycle writeback visible on the read ports.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  a1_i,
  input  logic [4:0]  a2_i,
  input  logic        we_i,
  input  logic [4:0]  a3_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] regs_q [32];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) for (int k = 0; k < 32; k++) regs_q[k] <= '0;
    else if (we_i && a3_i != 5'd0) regs_q[a3_i] <= wd_i;
  end
`ifdef DECODE_WB_BYPASS_EN
  assign rd1_o = (we_i && a3_i != 5'd0 && a3_i == a1_i) ? wd_i : regs_q[a1_i];
  assign rd2_o = (we_i && a3_i != 5'd0 && a3_i == a2_i) ? wd_i : regs_q[a2_i];
`else
  assign rd1_o = regs_q[a1_i];
  assign rd2_o = regs_q[a2_i];
`endif
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode, register read, immediate extension and ID/EX register with load-use stall.
// Register-file write-through is enabled by DECODE_WB_BYPASS_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic        flush_e,
  input  logic        reg_write_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] result_w,
  output logic        reg_write_e,
  output logic        mem_write_e,
  output logic [1:0]  result_src_e,
  output logic        alu_src_e,
  output logic [2:0]  alu_control_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_ext_e,
  output logic [31:0] pc_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic        stall_d
);
  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;
  localparam idex_t BUBBLE = '{pc: RESET_PC, default: '0};
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [2:0]  alu_fn;
  ctrl_t       ctrl;
  imm_t        imm_sel;
  logic [31:0] rd1, rd2;
  idex_t       idex_d, idex_q;
  assign op = instr_d[6:0];
  assign f3 = instr_d[14:12];
  // Only R-type honours funct7[5]; addi never becomes sub.
  assign alu_fn = f3 == 3'b000 ? ((op == OP_R && instr_d[30]) ? ALU_SUB : ALU_ADD) :
                  f3 == 3'b010 ? ALU_SLT :
                  f3 == 3'b110 ? ALU_OR  :
                  f3 == 3'b111 ? ALU_AND : ALU_ADD;
  always_comb begin
    ctrl = '0;
    imm_sel = IMM_I;
    case (op)
      OP_LW:  ctrl = '{1'b1, 1'b0, RES_MEM, 1'b1, ALU_ADD, 1'b0, 1'b0};
      OP_SW:  begin ctrl = '{1'b0, 1'b1, RES_ALU, 1'b1, ALU_ADD, 1'b0, 1'b0}; imm_sel = IMM_S; end
      OP_R:   ctrl = '{1'b1, 1'b0, RES_ALU, 1'b0, alu_fn, 1'b0, 1'b0};
      OP_I:   ctrl = '{1'b1, 1'b0, RES_ALU, 1'b1, alu_fn, 1'b0, 1'b0};
      OP_BEQ: begin ctrl = '{1'b0, 1'b0, RES_ALU, 1'b0, ALU_SUB, 1'b1, 1'b0}; imm_sel = IMM_B; end
      OP_JAL: begin ctrl = '{1'b1, 1'b0, RES_PC4, 1'b0, ALU_ADD, 1'b0, 1'b1}; imm_sel = IMM_J; end
      default: ;
    endcase
  end
  reg_file u_rf (
    .clk   (clk),
    .rst   (rst),
    .a1_i  (instr_d[19:15]),
    .a2_i  (instr_d[24:20]),
    .we_i  (reg_write_w),
    .a3_i  (rd_w),
    .wd_i  (result_w),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );
  // rs2 is compared for every format; the extra stalls on I-type are accepted.
  assign stall_d = idex_q.ctrl.result_src == RES_MEM && idex_q.rd != 5'd0 &&
                   (idex_q.rd == instr_d[19:15] || idex_q.rd == instr_d[24:20]);
  assign idex_d = (flush_e || stall_d) ? BUBBLE :
                  {ctrl, rd1, rd2, imm_ext(instr_d, imm_sel), pc_d, instr_d[19:15], instr_d[24:20], instr_d[11:7]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= BUBBLE;
    else idex_q <= idex_d;
  end
  assign reg_write_e   = idex_q.ctrl.reg_write;
  assign mem_write_e   = idex_q.ctrl.mem_write;
  assign result_src_e  = idex_q.ctrl.result_src;
  assign alu_src_e     = idex_q.ctrl.alu_src;
  assign alu_control_e = idex_q.ctrl.alu_control;
  assign branch_e      = idex_q.ctrl.branch;
  assign jump_e        = idex_q.ctrl.jump;
  assign rd1_e         = idex_q.rd1;
  assign rd2_e         = idex_q.rd2;
  assign imm_ext_e     = idex_q.imm;
  assign pc_e          = idex_q.pc;
  assign rs1_e         = idex_q.rs1;
  assign rs2_e         = idex_q.rs2;
  assign rd_e          = idex_q.rd;
endmodule
